// File: rtl/fsm_send_frame.sv
// Frame sender: captures the averager result, then streams an optional start code
// and the result bytes LSB-first to the UART TX, pacing each byte by a minimum gap.
module fsm_send_frame #(
  parameter int          NBYTES     = 2,
  parameter int          GAP_CYCLES = 100,
  parameter int          TIMER_W    = 16,
  parameter int          USE_START  = 0,
  parameter logic [7:0]  START_CODE = 8'hA5,
  parameter int          USE_BUSY   = 1,
  localparam int         IDX_W      = $clog2(NBYTES + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_send,
  input  logic                  sum_ready,
  input  logic [8*NBYTES-1:0]   sum_data,
  input  logic                  tx_busy,
  output logic                  sum_en,
  output logic                  tx_send,
  output logic [7:0]            tx_data,
  output logic [IDX_W-1:0]      byte_idx,
  output logic                  frame_done
);

  localparam int                 L    = NBYTES + USE_START;
  localparam logic [IDX_W-1:0]   LAST = IDX_W'(L - 1);
  localparam logic [TIMER_W-1:0] GAP  = TIMER_W'(GAP_CYCLES);
  localparam logic [TIMER_W-1:0] TMAX = '1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_SUM  = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_WAIT_BYTE = 3'd3;

  logic [2:0]          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q;
  logic [IDX_W-1:0]    slot_q;
  logic [8*NBYTES-1:0] shadow_q;
  logic [7:0]          tx_data_q;
  logic                gap_done;
  logic                last_slot;

  // Slot 0 carries the start code when enabled; remaining slots map onto result bytes.
  function automatic logic [7:0] slot_byte(input logic [8*NBYTES-1:0] sh,
                                           input logic [IDX_W-1:0]    s);
    logic [7:0] b;
    b = START_CODE;
    for (int i = 0; i < NBYTES; i++) begin
      if (int'(s) - USE_START == i) b = sh[8*i +: 8];
    end
    return b;
  endfunction

  assign gap_done  = (timer_q >= GAP) && ((USE_BUSY == 0) || !tx_busy);
  assign last_slot = (slot_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (en_send) state_d = S_WAIT_SUM;
      S_WAIT_SUM: begin
        if (sum_ready)     state_d = S_SEND;
        else if (!en_send) state_d = S_IDLE;
      end
      S_SEND:      state_d = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (gap_done) begin
          if (!last_slot)   state_d = S_SEND;
          else if (en_send) state_d = S_WAIT_SUM;
          else              state_d = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  assign sum_en     = (state_q == S_WAIT_SUM);
  assign tx_send    = (state_q == S_SEND);
  assign frame_done = (state_q == S_WAIT_BYTE) && gap_done && last_slot;
  assign tx_data    = tx_data_q;
  assign byte_idx   = slot_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      slot_q    <= '0;
      shadow_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      // Gap timer only counts while parked in WAIT_BYTE and saturates instead of wrapping.
      if ((state_d != state_q) || (state_q != S_WAIT_BYTE)) timer_q <= '0;
      else if (timer_q != TMAX)                               timer_q <= timer_q + 1'b1;
      if ((state_q == S_WAIT_SUM) && sum_ready) begin
        shadow_q  <= sum_data;
        slot_q    <= '0;
        tx_data_q <= slot_byte(sum_data, '0);
      end else if ((state_q == S_WAIT_BYTE) && gap_done && !last_slot) begin
        slot_q    <= slot_q + 1'b1;
        tx_data_q <= slot_byte(shadow_q, slot_q + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_send_frame.sv
// Bench for fsm_send_frame: start code enabled, 3 result bytes, gap of 4, busy gating on.
module tb_fsm_send_frame;

  localparam int NB  = 3;
  localparam int GAP = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_send = 1'b0;
  logic        sum_ready = 1'b0;
  logic [23:0] sum_data = '0;
  logic        tx_busy = 1'b0;
  logic        sum_en, tx_send, frame_done;
  logic [7:0]  tx_data;
  logic [2:0]  byte_idx;

  exp_t sb[$];
  exp_t e;
  int   send_cyc[$];
  int   total = 0, bad = 0;
  int   cyc = 0, n_sends = 0, n_done = 0, done_cyc = 0, frame_no = 0, fall = 0;
  logic inject = 1'b0;

  fsm_send_frame #(
    .NBYTES(NB), .GAP_CYCLES(GAP), .TIMER_W(16), .USE_START(1),
    .START_CODE(8'hA5), .USE_BUSY(1)
  ) dut (
    .clk(clk), .reset(reset), .en_send(en_send), .sum_ready(sum_ready),
    .sum_data(sum_data), .tx_busy(tx_busy), .sum_en(sum_en), .tx_send(tx_send),
    .tx_data(tx_data), .byte_idx(byte_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_sends(input int target);
    for (int i = 0; i < 400; i++) begin
      if (n_sends >= target) return;
      @(negedge clk); #1;
    end
    check("timeout_sends", n_sends, target);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400; i++) begin
      if (n_done >= target) return;
      @(negedge clk); #1;
    end
    check("timeout_done", n_done, target);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every send strobe is scored against the head of the queue.
  initial forever begin
    @(negedge clk);
    if (reset && tx_send) begin
      send_cyc.push_back(cyc);
      n_sends++;
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e.d});
        check("byte_idx", {29'd0, byte_idx}, {29'd0, e.idx});
      end
    end
    if (reset && frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // Averager model: answers sum_en with a result and queues the frame it should produce.
  initial forever begin
    @(negedge clk);
    sum_ready = 1'b0;
    if (sum_en) begin
      sum_data  = (frame_no == 0) ? 24'h123456 : 24'($urandom);
      frame_no++;
      sum_ready = 1'b1;
      sb.push_back('{d: 8'hA5, idx: 3'd0});
      for (int k = 0; k < NB; k++) sb.push_back('{d: sum_data[8*k +: 8], idx: 3'(k + 1)});
    end else if (inject) begin
      sum_ready = 1'b1;
      sum_data  = 24'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    @(negedge clk); #1;
    check("rst_sum_en", {31'd0, sum_en}, 32'd0);
    check("rst_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_byte_idx", {29'd0, byte_idx}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);

    @(negedge clk);
    reset   = 1'b1;
    en_send = 1'b1;
    wait_sends(4);
    wait_done(1);
    check("spacing_0_1", send_cyc[1] - send_cyc[0], GAP + 2);
    check("spacing_1_2", send_cyc[2] - send_cyc[1], GAP + 2);
    check("spacing_2_3", send_cyc[3] - send_cyc[2], GAP + 2);
    check("done_latency", done_cyc - send_cyc[3], GAP + 1);
    @(negedge clk); #1;
    check("back_to_wait_sum", {31'd0, sum_en}, 32'd1);

    wait_sends(5);
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("busy_hold", n_sends, 5);
    tx_busy = 1'b0;
    fall    = cyc;
    wait_sends(6);
    check("busy_release", send_cyc[5] - fall, 1);
    wait_done(2);

    wait_sends(9);
    en_send = 1'b0;
    wait_done(3);
    check("drop_all_sent", n_sends, 12);
    @(negedge clk); #1;
    check("drop_idle_sum_en", {31'd0, sum_en}, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("idle_quiet", n_sends, 12);
    check("idle_frames", n_done, 3);

    en_send = 1'b1;
    wait_sends(14);
    reset = 1'b0;
    #1;
    check("arst_tx_send", {31'd0, tx_send}, 32'd0);
    check("arst_sum_en", {31'd0, sum_en}, 32'd0);
    check("arst_byte_idx", {29'd0, byte_idx}, 32'd0);
    check("arst_tx_data", {24'd0, tx_data}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("restart_wait_sum", {31'd0, sum_en}, 32'd1);

    wait_sends(15);
    inject  = 1'b1;
    en_send = 1'b0;
    wait_done(4);
    inject = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("final_sends", n_sends, 18);
    check("final_idle", {31'd0, sum_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
